three_bit_reg: RTL and testbench



---
 rtl/three_bit_reg_pkg.sv | 12 +
 rtl/reg_bit_cell.sv | 22 ++
 rtl/three_bit_reg.sv | 40 ++++
 tb/tb_three_bit_reg.sv | 136 +++++++++++++
 4 files changed

// File: rtl/three_bit_reg_pkg.sv
// Shared defaults and helpers for the three_bit_reg parallel-load register.
package three_bit_reg_pkg;

  localparam int         DEFAULT_WIDTH   = 3;
  localparam logic [2:0] DEFAULT_RST_VAL = 3'b000;

  // Even parity of a vector up to 32 bits; zero-extension does not change it.
  function automatic logic parity_f(input logic [31:0] vector);
    return ^vector;
  endfunction

endpackage

// File: rtl/reg_bit_cell.sv
// One storage bit: synchronous reset to a fixed value, load mux, otherwise hold.
module reg_bit_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic d,
  output logic q
);

  // NOTE: state is written with <= so every cell samples the pre-edge values;
  // the missing final else is a clock-enable hold on a flop, not a latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_BIT;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/three_bit_reg.sv
// Parallel-load register with load enable and synchronous active-high reset.
// Define THREE_BIT_REG_PARITY_EN to add the even-parity output par.
module three_bit_reg
  import three_bit_reg_pkg::*;
#(
  parameter int          WIDTH   = DEFAULT_WIDTH,
  parameter logic [31:0] RST_VAL = 32'(DEFAULT_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
`ifdef THREE_BIT_REG_PARITY_EN
  output logic             par,
`endif
  output logic [WIDTH-1:0] out
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("three_bit_reg: WIDTH must be in 1..32");
  end

  // RST_VAL is truncated to WIDTH bits by taking one bit per cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg_bit_cell #(
      .RST_BIT(RST_VAL[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .ld (ld),
      .d  (in[i]),
      .q  (out[i])
    );
  end

`ifdef THREE_BIT_REG_PARITY_EN
  assign par = parity_f(32'(out));
`endif

endmodule

// File: tb/tb_three_bit_reg.sv
// Self-checking bench for three_bit_reg: directed cases then randomized traffic,
// two instances (reset value 0 and 3'b110) compared against a behavioural model.
module tb_three_bit_reg;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld  = 1'b0;
  logic [W-1:0] in  = '0;
  logic [W-1:0] out0, out1;
`ifdef THREE_BIT_REG_PARITY_EN
  logic         par0, par1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: value each register should hold, and whether it is defined yet.
  logic [W-1:0] exp0, exp1;
  bit           known = 1'b0;

  always #5 clk = ~clk;

  three_bit_reg dut0 (
    .clk(clk),
    .rst(rst),
    .ld (ld),
    .in (in),
`ifdef THREE_BIT_REG_PARITY_EN
    .par(par0),
`endif
    .out(out0)
  );

  three_bit_reg #(
    .WIDTH  (W),
    .RST_VAL(32'b110)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .ld (ld),
    .in (in),
`ifdef THREE_BIT_REG_PARITY_EN
    .par(par1),
`endif
    .out(out1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      $display("FAIL %s: got %b expected %b at t=%0t", tag, got, want, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/out0"}, 32'(out0), 32'(exp0));
    check({tag, "/out1"}, 32'(out1), 32'(exp1));
`ifdef THREE_BIT_REG_PARITY_EN
    check({tag, "/par0"}, 32'(par0), 32'(^exp0));
    check({tag, "/par1"}, 32'(par1), 32'(^exp1));
`endif
  endtask

  // Apply inputs, confirm out ignores them between edges, clock once, update
  // the model from the priority rules and compare one time unit after the edge.
  task automatic step(input logic r, input logic l, input logic [W-1:0] d,
                      input bit do_check, input string tag);
    rst = r;
    ld  = l;
    in  = d;
    #2;
    if (do_check && known) begin
      check({tag, "/stable0"}, 32'(out0), 32'(exp0));
      check({tag, "/stable1"}, 32'(out1), 32'(exp1));
    end
    @(posedge clk);
    if (r) begin
      exp0  = '0;
      exp1  = 3'b110;
      known = 1'b1;
    end else if (l) begin
      exp0  = d;
      exp1  = d;
      known = 1'b1;
    end
    #1;
    if (do_check && known) check_outputs(tag);
  endtask

  initial begin
    // Idle: no reset issued, out is undefined and not checked.
    repeat (3) step(1'b0, 1'b0, 3'b000, 1'b0, "idle");

    step(1'b1 - 1'b1, 1'b1, 3'b101, 1'b1, "load");
    repeat (2) step(1'b0, 1'b1, 3'b101, 1'b1, "load_repeat");
    repeat (3) step(1'b0, 1'b0, 3'b010, 1'b1, "hold");
    step(1'b1, 1'b0, 3'b010, 1'b1, "reset");
    step(1'b0, 1'b1, 3'b011, 1'b1, "reload");
    step(1'b1, 1'b1, 3'b111, 1'b1, "prio_rst");
    step(1'b0, 1'b1, 3'b111, 1'b1, "prio_load");

    // Parity corner values.
    step(1'b0, 1'b1, 3'b101, 1'b1, "par_101");
    step(1'b0, 1'b1, 3'b100, 1'b1, "par_100");
    step(1'b1, 1'b0, 3'b000, 1'b1, "par_rst");

    // Back-to-back loads of distinct values.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, W'(i), 1'b1, "b2b");
    end

    // Randomized traffic: occasional reset, roughly half the edges load.
    for (int i = 0; i < 300; i++) begin
      logic r_i, l_i;
      logic [W-1:0] d_i;
      r_i = ($urandom_range(0, 9) == 0);
      l_i = 1'($urandom);
      d_i = W'($urandom);
      step(r_i, l_i, d_i, 1'b1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion by t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
